// File: rtl/cv_ctrl_mux_if.sv
// Controller-port bundle for cv_ctrl_mux: per-port joystick inputs, strobes and
// the active-low pin outputs. The master side drives inputs, the slave side is the mux.
interface cv_ctrl_mux_if #(
  parameter int NUM_PORTS = 2
);
  logic [16*NUM_PORTS-1:0] joy_i;
  logic [NUM_PORTS-1:0]    autofire_en_i;
  logic [NUM_PORTS-1:0]    spin_en_i;
  logic [NUM_PORTS-1:0]    ctrl_p5_i;
  logic [NUM_PORTS-1:0]    ctrl_p8_i;
  logic [4*NUM_PORTS-1:0]  ctrl_p14_o;
  logic [NUM_PORTS-1:0]    ctrl_p6_o;
  logic [NUM_PORTS-1:0]    ctrl_p7_o;
  logic [NUM_PORTS-1:0]    ctrl_p9_o;

  modport master (
    output joy_i, autofire_en_i, spin_en_i, ctrl_p5_i, ctrl_p8_i,
    input  ctrl_p14_o, ctrl_p6_o, ctrl_p7_o, ctrl_p9_o
  );

  modport slave (
    input  joy_i, autofire_en_i, spin_en_i, ctrl_p5_i, ctrl_p8_i,
    output ctrl_p14_o, ctrl_p6_o, ctrl_p7_o, ctrl_p9_o
  );
endinterface

// File: rtl/cv_ctrl_mux.sv
// ColecoVision controller multiplexer: PS/2 keyboard plus joysticks to keypad /
// joystick nibbles, with shared autofire timebase and per-port spinner quadrature.
module cv_ctrl_mux #(
  parameter int          NUM_PORTS = 2,
  parameter logic [15:0] AF_PERIOD = 16'd53000,
  parameter logic [15:0] SPIN_DIV  = 16'd8000
) (
  input  logic         clk_i,
  input  logic         reset_n_i,
  input  logic         clk_en_i,
  input  logic [10:0]  ps2_key_i,
  cv_ctrl_mux_if.slave bus
);
  // Keypad codes indexed by priority: 0..9, *, #, purple, blue (index 0 at LSB).
  localparam logic [55:0] KP_CODES = {
    4'b0010, 4'b0100, 4'b0101, 4'b1010, 4'b1011, 4'b1000, 4'b1100,
    4'b0111, 4'b1001, 4'b0001, 4'b0110, 4'b1101, 4'b1110, 4'b0011
  };

  // r_kbd[15:0] mirrors the joy_i bit layout; [21:16] are keypad keys 4..9.
  logic        r_ps2_tog;
  logic [21:0] r_kbd;
  logic [21:0] w_hit;
  logic [15:0] r_af_cnt;
  logic        r_af_phase;

  always_comb begin
    w_hit = '0;
    case (ps2_key_i[7:0])
      8'h75:        w_hit[3]  = 1'b1;
      8'h72:        w_hit[2]  = 1'b1;
      8'h6B:        w_hit[1]  = 1'b1;
      8'h74:        w_hit[0]  = 1'b1;
      8'h22, 8'h45: w_hit[8]  = 1'b1;
      8'h16:        w_hit[9]  = 1'b1;
      8'h1E:        w_hit[10] = 1'b1;
      8'h26:        w_hit[11] = 1'b1;
      8'h15, 8'h25: w_hit[16] = 1'b1;
      8'h1D, 8'h2E: w_hit[17] = 1'b1;
      8'h24, 8'h36: w_hit[18] = 1'b1;
      8'h1C, 8'h3D: w_hit[19] = 1'b1;
      8'h1B, 8'h3E: w_hit[20] = 1'b1;
      8'h23, 8'h46: w_hit[21] = 1'b1;
      8'h1A:        w_hit[6]  = 1'b1;
      8'h21:        w_hit[7]  = 1'b1;
      8'h1F, 8'h27: w_hit[12] = 1'b1;
      8'h11:        w_hit[13] = 1'b1;
      8'h14:        w_hit[4]  = 1'b1;
      default:      ;
    endcase
    // Fire2 is the two shift keys only, so the extended flag matters here.
    if (ps2_key_i[8:0] == 9'h012 || ps2_key_i[8:0] == 9'h059)
      w_hit[5] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_ps2_tog <= 1'b0;
      r_kbd     <= '0;
    end else begin
      r_ps2_tog <= ps2_key_i[10];
      if (ps2_key_i[10] != r_ps2_tog)
        r_kbd <= (r_kbd & ~w_hit) | (w_hit & {22{ps2_key_i[9]}});
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_af_cnt   <= '0;
      r_af_phase <= 1'b0;
    end else if (clk_en_i) begin
      if (r_af_cnt == AF_PERIOD - 16'd1) begin
        r_af_cnt   <= '0;
        r_af_phase <= ~r_af_phase;
      end else begin
        r_af_cnt <= r_af_cnt + 16'd1;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
    logic [15:0] w_joy;
    logic [5:0]  w_kbd_only;
    logic [13:0] w_keys;
    logic [3:0]  w_pad;
    logic [3:0]  w_nib5;
    logic [3:0]  w_nib8;
    logic        w_fire1_eff;
    logic        w_fire5;
    logic        w_fire8;
    logic        w_right;
    logic        w_left;
    logic [1:0]  w_quad_fwd;
    logic [1:0]  w_quad_rev;
    logic [3:0]  r_p14;
    logic        r_p6;
    logic [15:0] r_div;
    logic [1:0]  r_quad;

    if (gi == 0) begin : g_kbd
      assign w_joy      = bus.joy_i[15:0] | r_kbd[15:0];
      assign w_kbd_only = r_kbd[21:16];
    end else begin : g_nokbd
      assign w_joy      = bus.joy_i[16*gi +: 16];
      assign w_kbd_only = '0;
    end

    assign w_keys = {w_joy[13], w_joy[12], w_joy[7], w_joy[6], w_kbd_only, w_joy[11:8]};

    always_comb begin
      w_pad = 4'b1111;
      for (int k = 13; k >= 0; k--)
        if (w_keys[k]) w_pad = KP_CODES[4*k +: 4];
    end

    assign w_fire1_eff = w_joy[4] & (~bus.autofire_en_i[gi] | r_af_phase);
    assign w_nib5  = bus.ctrl_p5_i[gi] ? 4'b1111 : w_pad;
    assign w_nib8  = bus.ctrl_p8_i[gi] ? 4'b1111 : ~w_joy[3:0];
    assign w_fire5 = bus.ctrl_p5_i[gi] | ~w_joy[5];
    assign w_fire8 = bus.ctrl_p8_i[gi] | ~w_fire1_eff;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        r_p14 <= 4'b1111;
        r_p6  <= 1'b1;
      end else begin
        r_p14 <= w_nib5 & w_nib8;
        r_p6  <= w_fire5 & w_fire8;
      end
    end

    // Gray stepping: forward 11->10->00->01, reverse is the mirror.
    assign w_right    = w_joy[15] & ~w_joy[14];
    assign w_left     = w_joy[14] & ~w_joy[15];
    assign w_quad_fwd = {r_quad[0], ~r_quad[1]};
    assign w_quad_rev = {~r_quad[0], r_quad[1]};

    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        r_div  <= '0;
        r_quad <= 2'b11;
      end else if (!bus.spin_en_i[gi]) begin
        r_div  <= '0;
        r_quad <= 2'b11;
      end else if (w_right == w_left) begin
        r_div <= '0;
      end else if (clk_en_i) begin
        if (r_div == SPIN_DIV - 16'd1) begin
          r_div  <= '0;
          r_quad <= w_right ? w_quad_fwd : w_quad_rev;
        end else begin
          r_div <= r_div + 16'd1;
        end
      end
    end

    assign bus.ctrl_p14_o[4*gi +: 4] = r_p14;
    assign bus.ctrl_p6_o[gi]         = r_p6;
    assign bus.ctrl_p7_o[gi]         = r_quad[0];
    assign bus.ctrl_p9_o[gi]         = r_quad[1];
  end
endmodule

// File: tb/tb_cv_ctrl_mux.sv
// Bench for cv_ctrl_mux: directed stimulus, a key/timebase model checked every
// cycle, and literal expectations at the points the controller behaviour is pinned.
module tb_cv_ctrl_mux;
  localparam int NP = 2;
  localparam int AF = 4;
  localparam int SD = 2;

  localparam logic [3:0] KP [14] = '{4'b0011, 4'b1110, 4'b1101, 4'b0110, 4'b0001,
                                     4'b1001, 4'b0111, 4'b1100, 4'b1000, 4'b1011,
                                     4'b1010, 4'b0101, 4'b0100, 4'b0010};
  localparam logic [1:0] QSEQ [4] = '{2'b11, 2'b10, 2'b00, 2'b01};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clk_en = 1'b0;
  logic [10:0] ps2_key = '0;
  int          n_checks = 0;
  int          n_errors = 0;
  bit          cmp_on = 1'b0;

  cv_ctrl_mux_if #(.NUM_PORTS(NP)) bus ();

  cv_ctrl_mux #(.NUM_PORTS(NP), .AF_PERIOD(16'(AF)), .SPIN_DIV(16'(SD))) dut (
    .clk_i    (clk),
    .reset_n_i(rst_n),
    .clk_en_i (clk_en),
    .ps2_key_i(ps2_key),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  // Model state; key indices: 0..9 digits, 10 *, 11 #, 12 purple, 13 blue,
  // 14 up, 15 down, 16 left, 17 right, 18 fire1, 19 fire2.
  bit          m_key [20];
  bit          m_tog;
  int          m_af_cnt;
  bit          m_af_ph;
  int          m_pos [NP];
  int          m_div [NP];
  logic [7:0]  e_p14;
  logic [1:0]  e_p6, e_p7, e_p9;

  function automatic int m_decode(input logic [8:0] c);
    if (c == 9'h012 || c == 9'h059) return 19;
    case (c[7:0])
      8'h75: return 14;
      8'h72: return 15;
      8'h6B: return 16;
      8'h74: return 17;
      8'h22, 8'h45: return 0;
      8'h16: return 1;
      8'h1E: return 2;
      8'h26: return 3;
      8'h15, 8'h25: return 4;
      8'h1D, 8'h2E: return 5;
      8'h24, 8'h36: return 6;
      8'h1C, 8'h3D: return 7;
      8'h1B, 8'h3E: return 8;
      8'h23, 8'h46: return 9;
      8'h1A: return 10;
      8'h21: return 11;
      8'h1F, 8'h27: return 12;
      8'h11: return 13;
      8'h14: return 18;
      default: return -1;
    endcase
  endfunction

  task automatic model_step();
    logic [15:0] j;
    bit          pr [14];
    bit          kb, up, dn, lf, rt, f1, f2, f1e, f5, f8, r, l;
    logic [3:0]  pad, n5, n8;
    logic [1:0]  q;
    int          k;
    if (!rst_n) begin
      foreach (m_key[i]) m_key[i] = 1'b0;
      m_tog = 1'b0; m_af_cnt = 0; m_af_ph = 1'b0;
      for (int p = 0; p < NP; p++) begin m_pos[p] = 0; m_div[p] = 0; end
      e_p14 = '1; e_p6 = '1; e_p7 = '1; e_p9 = '1;
      return;
    end
    for (int p = 0; p < NP; p++) begin
      j  = bus.joy_i[16*p +: 16];
      kb = (p == 0);
      up = j[3] || (kb && m_key[14]);
      dn = j[2] || (kb && m_key[15]);
      lf = j[1] || (kb && m_key[16]);
      rt = j[0] || (kb && m_key[17]);
      f1 = j[4] || (kb && m_key[18]);
      f2 = j[5] || (kb && m_key[19]);
      for (int d = 0; d < 4; d++) pr[d] = j[8+d] || (kb && m_key[d]);
      for (int d = 4; d < 10; d++) pr[d] = kb && m_key[d];
      pr[10] = j[6]  || (kb && m_key[10]);
      pr[11] = j[7]  || (kb && m_key[11]);
      pr[12] = j[12] || (kb && m_key[12]);
      pr[13] = j[13] || (kb && m_key[13]);
      pad = 4'b1111;
      for (int d = 0; d < 14; d++) if (pr[d]) begin pad = KP[d]; break; end
      f1e = f1 && (!bus.autofire_en_i[p] || m_af_ph);
      n5  = bus.ctrl_p5_i[p] ? 4'b1111 : pad;
      n8  = bus.ctrl_p8_i[p] ? 4'b1111 : ~{up, dn, lf, rt};
      f5  = bus.ctrl_p5_i[p] ? 1'b1 : !f2;
      f8  = bus.ctrl_p8_i[p] ? 1'b1 : !f1e;
      e_p14[4*p +: 4] = n5 & n8;
      e_p6[p] = f5 & f8;
      r = j[15] && !j[14];
      l = j[14] && !j[15];
      if (!bus.spin_en_i[p]) begin
        m_pos[p] = 0; m_div[p] = 0;
      end else if (!r && !l) begin
        m_div[p] = 0;
      end else if (clk_en) begin
        m_div[p] = m_div[p] + 1;
        if (m_div[p] == SD) begin
          m_div[p] = 0;
          m_pos[p] = r ? (m_pos[p] + 1) % 4 : (m_pos[p] + 3) % 4;
        end
      end
      q = QSEQ[m_pos[p]];
      e_p7[p] = q[0];
      e_p9[p] = q[1];
    end
    if (ps2_key[10] != m_tog) begin
      k = m_decode(ps2_key[8:0]);
      if (k >= 0) m_key[k] = ps2_key[9];
    end
    m_tog = ps2_key[10];
    if (clk_en) begin
      m_af_cnt = m_af_cnt + 1;
      if (m_af_cnt == AF) begin m_af_cnt = 0; m_af_ph = !m_af_ph; end
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    model_step();
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (cmp_on) begin
      chk("model_p14", 32'(bus.ctrl_p14_o), 32'(e_p14));
      chk("model_p6",  32'(bus.ctrl_p6_o),  32'(e_p6));
      chk("model_p7",  32'(bus.ctrl_p7_o),  32'(e_p7));
      chk("model_p9",  32'(bus.ctrl_p9_o),  32'(e_p9));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.joy_i = '0; bus.autofire_en_i = '0; bus.spin_en_i = '0;
    bus.ctrl_p5_i = '1; bus.ctrl_p8_i = '1; clk_en = 1'b0;
  endtask

  initial begin
    idle_inputs();
    ps2_key = '0;
    step(1);
    cmp_on = 1'b1;
    step(1);
    chk("reset_p14", 32'(bus.ctrl_p14_o), 32'hFF);
    chk("reset_p7p9", 32'({bus.ctrl_p9_o, bus.ctrl_p7_o}), 32'hF);
    rst_n = 1'b1;
    step(1);

    // Autofire on port 0: phase starts at 0, flips after every 4 enables.
    bus.joy_i[4] = 1'b1; bus.autofire_en_i[0] = 1'b1; bus.ctrl_p8_i[0] = 1'b0; clk_en = 1'b1;
    for (int s = 1; s <= 9; s++) begin
      step(1);
      if (s == 4) chk("af_p6_s4", 32'(bus.ctrl_p6_o[0]), 32'd1);
      if (s == 5) chk("af_p6_s5", 32'(bus.ctrl_p6_o[0]), 32'd0);
      if (s == 8) chk("af_p6_s8", 32'(bus.ctrl_p6_o[0]), 32'd0);
      if (s == 9) chk("af_p6_s9", 32'(bus.ctrl_p6_o[0]), 32'd1);
    end
    chk("af_p6_port1", 32'(bus.ctrl_p6_o[1]), 32'd1);
    bus.autofire_en_i[0] = 1'b0;
    step(1);
    chk("af_off_p6", 32'(bus.ctrl_p6_o[0]), 32'd0);
    idle_inputs();
    step(1);

    // Spinner on port 0.
    bus.spin_en_i[0] = 1'b1; bus.joy_i[15] = 1'b1; clk_en = 1'b1;
    step(2); chk("spin_r1", 32'({bus.ctrl_p9_o[0], bus.ctrl_p7_o[0]}), 32'b10);
    step(2); chk("spin_r2", 32'({bus.ctrl_p9_o[0], bus.ctrl_p7_o[0]}), 32'b00);
    step(2); chk("spin_r3", 32'({bus.ctrl_p9_o[0], bus.ctrl_p7_o[0]}), 32'b01);
    step(2); chk("spin_r4", 32'({bus.ctrl_p9_o[0], bus.ctrl_p7_o[0]}), 32'b11);
    bus.joy_i[15] = 1'b0; bus.joy_i[14] = 1'b1;
    step(2); chk("spin_l1", 32'({bus.ctrl_p9_o[0], bus.ctrl_p7_o[0]}), 32'b01);
    step(2); chk("spin_l2", 32'({bus.ctrl_p9_o[0], bus.ctrl_p7_o[0]}), 32'b00);
    bus.joy_i[15] = 1'b1;
    step(4); chk("spin_both", 32'({bus.ctrl_p9_o[0], bus.ctrl_p7_o[0]}), 32'b00);
    bus.joy_i = '0; bus.spin_en_i[0] = 1'b0;
    step(1); chk("spin_off", 32'({bus.ctrl_p9_o[0], bus.ctrl_p7_o[0]}), 32'b11);
    idle_inputs();

    // Keyboard key 1 on port 0 keypad: two-clock latency from the toggle.
    bus.ctrl_p5_i = 2'b00;
    ps2_key = {1'b1, 1'b1, 9'h016};
    step(1); chk("kb1_lat1", 32'(bus.ctrl_p14_o[3:0]), 32'b1111);
    step(1); chk("kb1_p14", 32'(bus.ctrl_p14_o[3:0]), 32'b1110);
    chk("kb1_p6", 32'(bus.ctrl_p6_o[0]), 32'd1);
    chk("kb1_port1", 32'(bus.ctrl_p14_o[7:4]), 32'b1111);
    ps2_key = {1'b0, 1'b0, 9'h016};
    step(2); chk("kb1_rel", 32'(bus.ctrl_p14_o[3:0]), 32'b1111);

    // Key 5 via extended 2E (flag ignored), then fire2 only on exact codes.
    ps2_key = {1'b1, 1'b1, 9'h12E};
    step(2); chk("kb5_p14", 32'(bus.ctrl_p14_o[3:0]), 32'b1001);
    ps2_key = {1'b0, 1'b0, 9'h12E};
    step(2); chk("kb5_rel", 32'(bus.ctrl_p14_o[3:0]), 32'b1111);
    ps2_key = {1'b1, 1'b1, 9'h112};
    step(2); chk("ext12_p6", 32'(bus.ctrl_p6_o[0]), 32'd1);
    ps2_key = {1'b0, 1'b1, 9'h012};
    step(2); chk("fire2_p6", 32'(bus.ctrl_p6_o[0]), 32'd0);
    ps2_key = {1'b1, 1'b0, 9'h012};
    step(2); chk("fire2_rel", 32'(bus.ctrl_p6_o[0]), 32'd1);

    // Extended up arrow into joystick nibble.
    bus.ctrl_p5_i = 2'b11; bus.ctrl_p8_i[0] = 1'b0;
    ps2_key = {1'b0, 1'b1, 9'h175};
    step(2); chk("kb_up_p14", 32'(bus.ctrl_p14_o[3:0]), 32'b0111);
    ps2_key = {1'b1, 1'b0, 9'h175};
    step(2); chk("kb_up_rel", 32'(bus.ctrl_p14_o[3:0]), 32'b1111);
    idle_inputs();

    // Port 1 joystick keypad priority and nibble AND.
    bus.joy_i[24] = 1'b1; bus.joy_i[27] = 1'b1; bus.ctrl_p5_i[1] = 1'b0;
    step(1); chk("p1_key0", 32'(bus.ctrl_p14_o[7:4]), 32'b0011);
    bus.joy_i[19] = 1'b1; bus.ctrl_p8_i[1] = 1'b0;
    step(1); chk("p1_and", 32'(bus.ctrl_p14_o[7:4]), 32'b0011);
    idle_inputs();
    step(1);

    // Reset mid-spin and mid-keypress.
    bus.spin_en_i[0] = 1'b1; bus.joy_i[15] = 1'b1; clk_en = 1'b1; bus.ctrl_p5_i[0] = 1'b0;
    ps2_key = {1'b0, 1'b1, 9'h02E};
    step(3);
    chk("pre_rst_p14", 32'(bus.ctrl_p14_o[3:0]), 32'b1001);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_p14", 32'(bus.ctrl_p14_o), 32'hFF);
    chk("arst_p6p7p9", 32'({bus.ctrl_p6_o, bus.ctrl_p7_o, bus.ctrl_p9_o}), 32'h3F);
    idle_inputs();
    ps2_key = '0;
    step(2);
    rst_n = 1'b1;
    bus.ctrl_p5_i[0] = 1'b0;
    step(3);
    chk("post_rst_p14", 32'(bus.ctrl_p14_o), 32'hFF);
    step(1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
